// File: rtl/diad_memarb.sv
`default_nettype none
// ============================================================================
// Module      : diad_memarb
// Description : Single-port memory arbiter shared by the IF (read-only) and
//               MA (read/write) stages of the Diad core.
// Revision    : 1.0 - initial release
// ============================================================================
module diad_memarb #(
    parameter int ADDR_W     = 24,
    parameter int DATA_W     = 24,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_err,
    input  logic              ma_req,
    input  logic              ma_we,
    input  logic [ADDR_W-1:0] ma_addr,
    input  logic [DATA_W-1:0] ma_wdata,
    output logic              ma_ack,
    output logic [DATA_W-1:0] ma_rdata,
    output logic              ma_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              busy
);

    localparam int c_SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam int c_TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_SW-1:0] c_STARVE_MAX = c_SW'(STARVE_MAX);
    localparam logic [c_TW-1:0] c_TMO_LAST   = (TIMEOUT > 0) ? c_TW'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_owner_ma;
    logic [c_SW-1:0]   r_starve_cnt;
    logic [c_TW-1:0]   r_tmo_cnt;
    logic              r_if_ack;
    logic [DATA_W-1:0] r_if_rdata;
    logic              r_if_err;
    logic              r_ma_ack;
    logic [DATA_W-1:0] r_ma_rdata;
    logic              r_ma_err;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_busy;
    logic              w_grant_if;

    // IF wins when it is alone, or when MA has starved it for STARVE_MAX grants.
    always_comb begin
        w_grant_if = 1'b0;
        if (if_req && !ma_req) begin
            w_grant_if = 1'b1;
        end else if (if_req && ma_req && (STARVE_MAX > 0) && (r_starve_cnt == c_STARVE_MAX)) begin
            w_grant_if = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_owner_ma   <= 1'b0;
            r_starve_cnt <= '0;
            r_tmo_cnt    <= '0;
            r_if_ack     <= 1'b0;
            r_if_rdata   <= '0;
            r_if_err     <= 1'b0;
            r_ma_ack     <= 1'b0;
            r_ma_rdata   <= '0;
            r_ma_err     <= 1'b0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_busy       <= 1'b0;
        end else begin
            // Response outputs live for the single RESP cycle only.
            r_if_ack   <= 1'b0;
            r_if_rdata <= '0;
            r_if_err   <= 1'b0;
            r_ma_ack   <= 1'b0;
            r_ma_rdata <= '0;
            r_ma_err   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (if_req || ma_req) begin
                        r_state    <= ST_BUSY;
                        r_busy     <= 1'b1;
                        r_mem_req  <= 1'b1;
                        r_tmo_cnt  <= '0;
                        r_owner_ma <= !w_grant_if;
                        if (w_grant_if) begin
                            r_mem_we     <= 1'b0;
                            r_mem_addr   <= if_addr;
                            r_mem_wdata  <= '0;
                            r_starve_cnt <= '0;
                        end else begin
                            r_mem_we    <= ma_we;
                            r_mem_addr  <= ma_addr;
                            r_mem_wdata <= ma_wdata;
                            if (if_req) begin
                                if (r_starve_cnt != c_STARVE_MAX) begin
                                    r_starve_cnt <= r_starve_cnt + 1'b1;
                                end
                            end else begin
                                r_starve_cnt <= '0;
                            end
                        end
                    end
                end
                ST_BUSY: begin
                    if (mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_state   <= ST_RESP;
                        if (r_owner_ma) begin
                            r_ma_ack   <= 1'b1;
                            r_ma_rdata <= r_mem_we ? '0 : mem_rdata;
                        end else begin
                            r_if_ack   <= 1'b1;
                            r_if_rdata <= mem_rdata;
                        end
                    end else if ((TIMEOUT > 0) && (r_tmo_cnt == c_TMO_LAST)) begin
                        r_mem_req <= 1'b0;
                        r_state   <= ST_RESP;
                        if (r_owner_ma) begin
                            r_ma_ack <= 1'b1;
                            r_ma_err <= 1'b1;
                        end else begin
                            r_if_ack <= 1'b1;
                            r_if_err <= 1'b1;
                        end
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_busy    <= 1'b0;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    assign if_ack    = r_if_ack;
    assign if_rdata  = r_if_rdata;
    assign if_err    = r_if_err;
    assign ma_ack    = r_ma_ack;
    assign ma_rdata  = r_ma_rdata;
    assign ma_err    = r_ma_err;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_diad_memarb.sv
`default_nettype none
// ============================================================================
// Module      : tb_diad_memarb
// Description : Scoreboard bench for diad_memarb with a delay-programmable
//               memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_diad_memarb;

    localparam int c_AW = 24;
    localparam int c_DW = 24;

    logic            clk = 1'b0;
    logic            rst;
    logic            if_req;
    logic [c_AW-1:0] if_addr;
    logic            if_ack;
    logic [c_DW-1:0] if_rdata;
    logic            if_err;
    logic            ma_req;
    logic            ma_we;
    logic [c_AW-1:0] ma_addr;
    logic [c_DW-1:0] ma_wdata;
    logic            ma_ack;
    logic [c_DW-1:0] ma_rdata;
    logic            ma_err;
    logic            mem_req;
    logic            mem_we;
    logic [c_AW-1:0] mem_addr;
    logic [c_DW-1:0] mem_wdata;
    logic [c_DW-1:0] mem_rdata;
    logic            mem_ack;
    logic            busy;

    diad_memarb #(.ADDR_W(c_AW), .DATA_W(c_DW), .STARVE_MAX(4), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
        .ma_req(ma_req), .ma_we(ma_we), .ma_addr(ma_addr), .ma_wdata(ma_wdata),
        .ma_ack(ma_ack), .ma_rdata(ma_rdata), .ma_err(ma_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit              is_ma;
        logic [c_DW-1:0] rdata;
        bit              err;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Memory responder: acks rsp_delay cycles into a request (-1 = never); spur forces a stray ack.
    int              rsp_delay = -1;
    logic [c_DW-1:0] rsp_data  = '0;
    logic            spur      = 1'b0;
    logic            r_ack_m   = 1'b0;
    int              wait_cnt  = 0;
    assign mem_ack = r_ack_m | spur;

    initial begin
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_req && rsp_delay >= 0 && wait_cnt == rsp_delay) begin
                r_ack_m   = 1'b1;
                mem_rdata = rsp_data;
            end else if (mem_req) begin
                r_ack_m  = 1'b0;
                wait_cnt = wait_cnt + 1;
            end else begin
                r_ack_m  = 1'b0;
                wait_cnt = 0;
            end
        end
    end

    // Monitor: every ack pops one expected response.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (if_ack || ma_ack) begin
                n_cmp++;
                if (if_ack && ma_ack) begin
                    n_err++;
                    $display("FAIL both_acks: if_ack=1 ma_ack=1, required only one");
                end else if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_ack: if_ack=%0b ma_ack=%0b with no transaction outstanding", if_ack, ma_ack);
                end else begin
                    e = sb.pop_front();
                    if (e.is_ma != ma_ack ||
                        (ma_ack && (ma_rdata !== e.rdata || ma_err !== e.err)) ||
                        (if_ack && (if_rdata !== e.rdata || if_err !== e.err))) begin
                        n_err++;
                        $display("FAIL resp: got owner=%s rdata=%h err=%0b, required owner=%s rdata=%h err=%0b",
                                 ma_ack ? "MA" : "IF", ma_ack ? ma_rdata : if_rdata, ma_ack ? ma_err : if_err,
                                 e.is_ma ? "MA" : "IF", e.rdata, e.err);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic push(input bit is_ma, input logic [c_DW-1:0] rd, input bit err);
        exp_t e;
        e.is_ma = is_ma;
        e.rdata = rd;
        e.err   = err;
        sb.push_back(e);
    endtask

    // Returns at the negedge where an ack is visible, or flags a timeout.
    task automatic wait_ack(input string name);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (if_ack || ma_ack) return;
        end
        n_cmp++;
        n_err++;
        $display("FAIL %s: no ack within 100 cycles", name);
    endtask

    initial begin
        int cnt;
        rst = 1'b0; if_req = 1'b0; if_addr = '0;
        ma_req = 1'b0; ma_we = 1'b0; ma_addr = '0; ma_wdata = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_outputs", {if_ack, if_err, ma_ack, ma_err, mem_req, mem_we, busy, if_rdata, ma_rdata},
            '0);
        rst = 1'b1;
        @(negedge clk);

        // Asynchronous reset in the middle of a BUSY transaction
        rsp_delay = -1;
        ma_req = 1'b1; ma_we = 1'b0; ma_addr = 24'h000200;
        repeat (4) @(negedge clk);
        chk("t1_inflight", {mem_req, busy}, 2'b11);
        #2 rst = 1'b0;
        #1 chk("t1_async_reset", {mem_req, busy, ma_ack, if_ack}, 4'b0000);
        ma_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        chk("t1_idle_after_reset", {mem_req, busy}, 2'b00);

        // IF read, memory acks 2 cycles into BUSY
        rsp_delay = 2; rsp_data = 24'hABCDEF;
        push(1'b0, 24'hABCDEF, 1'b0);
        if_req = 1'b1; if_addr = 24'h000010;
        @(negedge clk);
        chk("t2_mem_cmd", {mem_req, mem_we, mem_addr, mem_wdata}, {1'b1, 1'b0, 24'h000010, 24'h0});
        wait_ack("t2_ack");
        if_req = 1'b0;
        @(negedge clk);

        // MA write: command must hold steady until mem_ack
        rsp_delay = 3; rsp_data = 24'h777777;
        push(1'b1, 24'h0, 1'b0);
        ma_req = 1'b1; ma_we = 1'b1; ma_addr = 24'h000100; ma_wdata = 24'h123456;
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (ma_ack) break;
            if (mem_req) begin
                cnt++;
                chk("t3_write_cmd", {mem_we, mem_addr, mem_wdata}, {1'b1, 24'h000100, 24'h123456});
            end
        end
        chk("t3_busy_cycles", 64'(cnt), 64'd4);
        ma_req = 1'b0; ma_we = 1'b0;
        @(negedge clk);

        // Starvation guard: both requesting, immediate ack
        rsp_delay = 0; rsp_data = 24'h0F0F0F;
        for (int k = 0; k < 10; k++) push((k % 5) != 4, 24'h0F0F0F, 1'b0);
        if_req = 1'b1; if_addr = 24'h000020;
        ma_req = 1'b1; ma_we = 1'b0; ma_addr = 24'h000300;
        for (int k = 0; k < 10; k++) wait_ack("t4_ack");
        if_req = 1'b0; ma_req = 1'b0;
        repeat (2) @(negedge clk);

        // Timeout: memory never answers
        rsp_delay = -1;
        push(1'b1, 24'h0, 1'b1);
        ma_req = 1'b1; ma_we = 1'b0; ma_addr = 24'h000400;
        cnt = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (mem_req) cnt++;
            if (ma_ack) break;
        end
        chk("t5_req_cycles", 64'(cnt), 64'd16);
        ma_req = 1'b0;
        @(negedge clk);

        // Spurious mem_ack in IDLE
        spur = 1'b1;
        @(negedge clk);
        chk("t6_idle_spur_1", {busy, mem_req}, 2'b00);
        @(negedge clk);
        chk("t6_idle_spur_2", {busy, mem_req}, 2'b00);
        spur = 1'b0;

        // Spurious mem_ack during RESP
        rsp_delay = 0; rsp_data = 24'h246802;
        push(1'b0, 24'h246802, 1'b0);
        if_req = 1'b1; if_addr = 24'h000030;
        wait_ack("t6_if_ack");
        if_req = 1'b0; spur = 1'b1;
        @(negedge clk);
        chk("t6_resp_spur_1", {busy, mem_req}, 2'b00);
        @(negedge clk);
        chk("t6_resp_spur_2", {busy, mem_req}, 2'b00);
        spur = 1'b0;

        // Normal transaction after the stray acks
        rsp_delay = 1; rsp_data = 24'h5A5A5A;
        push(1'b1, 24'h5A5A5A, 1'b0);
        ma_req = 1'b1; ma_we = 1'b0; ma_addr = 24'h000500;
        wait_ack("t6_ma_ack");
        ma_req = 1'b0;

        repeat (10) @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
